// File: rtl/pipe_pkg.sv
// Shared pipeline encodings: ALU op codes, forwarding selects and the
// control bundle carried from decode into execute.
package pipe_pkg;

  localparam int unsigned ALU_OP_W  = 3;
  localparam int unsigned FWD_SEL_W = 2;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_NOTHING = 3'b000,
    ALU_ADD     = 3'b001,
    ALU_SUB     = 3'b010,
    ALU_AND     = 3'b011,
    ALU_OR      = 3'b100,
    ALU_SLT     = 3'b101
  } alu_op_e;

  typedef enum logic [FWD_SEL_W-1:0] {
    FWD_NONE = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10
  } fwd_sel_e;

  // Decode control bits that travel with the instruction.
  typedef struct packed {
    logic alu_src;
    logic reg_dst;
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/forward_unit.sv
// Forwarding selection for one execute-stage source operand.
// The MEM stage result is younger than the WB result and wins when both match;
// register 0 is never forwarded and a bubble in execute never forwards.
module forward_unit
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              ex_valid,
  input  logic [REG_AW-1:0] src_reg,
  input  logic [DATA_W-1:0] src_data,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_result,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_result,
  output logic [1:0]        sel,
  output logic [DATA_W-1:0] data
);

  logic mem_hit;
  logic wb_hit;

  // Match detection against each producer stage.
  always_comb begin
    mem_hit = mem_reg_write && (mem_rd != '0) && (mem_rd == src_reg);
    wb_hit  = wb_reg_write  && (wb_rd  != '0) && (wb_rd  == src_reg);
  end

  // Priority select and operand mux.
  always_comb begin
    sel  = FWD_NONE;
    data = src_data;
    if (ex_valid) begin
      if (mem_hit) begin
        sel  = FWD_MEM;
        data = mem_result;
      end else if (wb_hit) begin
        sel  = FWD_WB;
        data = wb_result;
      end
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use detection.
// Stage registers capture decode on each unstalled edge; reset and flush load
// an all-zero bubble. Operand selection and hazard detection are combinational.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [2:0]        id_alu_op,
  input  logic              id_alu_src,
  input  logic              id_reg_dst,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_mem_to_reg,
  input  logic              mem_reg_write,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] mem_result,
  input  logic [DATA_W-1:0] wb_result,
  output logic [DATA_W-1:0] alu_lop,
  output logic [DATA_W-1:0] alu_rop,
  output logic [2:0]        alu_op,
  output logic              ex_valid,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg,
  output logic [REG_AW-1:0] ex_dest,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              load_use
);

  logic              valid_d,   valid_q;
  ctrl_t             ctrl_d,    ctrl_q;
  alu_op_e           alu_op_d,  alu_op_q;
  logic [DATA_W-1:0] rs_data_d, rs_data_q;
  logic [DATA_W-1:0] rt_data_d, rt_data_q;
  logic [DATA_W-1:0] imm_d,     imm_q;
  logic [REG_AW-1:0] rs_d,      rs_q;
  logic [REG_AW-1:0] rt_d,      rt_q;
  logic [REG_AW-1:0] rd_d,      rd_q;

  logic [DATA_W-1:0] rs_fwd_data;
  logic [DATA_W-1:0] rt_fwd_data;

  // Next stage contents: the decode slot, or a bubble when it is empty.
  always_comb begin
    valid_d   = 1'b0;
    ctrl_d    = CTRL_BUBBLE;
    alu_op_d  = ALU_NOTHING;
    rs_data_d = '0;
    rt_data_d = '0;
    imm_d     = '0;
    rs_d      = '0;
    rt_d      = '0;
    rd_d      = '0;
    if (id_valid) begin
      valid_d            = 1'b1;
      ctrl_d.alu_src     = id_alu_src;
      ctrl_d.reg_dst     = id_reg_dst;
      ctrl_d.reg_write   = id_reg_write;
      ctrl_d.mem_read    = id_mem_read;
      ctrl_d.mem_write   = id_mem_write;
      ctrl_d.mem_to_reg  = id_mem_to_reg;
      alu_op_d           = alu_op_e'(id_alu_op);
      rs_data_d          = id_rs_data;
      rt_data_d          = id_rt_data;
      imm_d              = id_imm;
      rs_d               = id_rs;
      rt_d               = id_rt;
      rd_d               = id_rd;
    end
  end

  // Stage register: reset/flush load a bubble, stall holds, otherwise capture.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid_q   <= 1'b0;
      ctrl_q    <= CTRL_BUBBLE;
      alu_op_q  <= ALU_NOTHING;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
    end else if (!stall) begin
      valid_q   <= valid_d;
      ctrl_q    <= ctrl_d;
      alu_op_q  <= alu_op_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      rd_q      <= rd_d;
    end
  end

  forward_unit #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_fwd_rs (
    .ex_valid      (valid_q),
    .src_reg       (rs_q),
    .src_data      (rs_data_q),
    .mem_reg_write (mem_reg_write),
    .mem_rd        (mem_rd),
    .mem_result    (mem_result),
    .wb_reg_write  (wb_reg_write),
    .wb_rd         (wb_rd),
    .wb_result     (wb_result),
    .sel           (fwd_a),
    .data          (rs_fwd_data)
  );

  forward_unit #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_fwd_rt (
    .ex_valid      (valid_q),
    .src_reg       (rt_q),
    .src_data      (rt_data_q),
    .mem_reg_write (mem_reg_write),
    .mem_rd        (mem_rd),
    .mem_result    (mem_result),
    .wb_reg_write  (wb_reg_write),
    .wb_rd         (wb_rd),
    .wb_result     (wb_result),
    .sel           (fwd_b),
    .data          (rt_fwd_data)
  );

  // Execute-side operand and control outputs.
  always_comb begin
    alu_op        = alu_op_q;
    alu_lop       = rs_fwd_data;
    alu_rop       = ctrl_q.alu_src ? imm_q : rt_fwd_data;
    ex_store_data = rt_fwd_data;
    ex_valid      = valid_q;
    ex_reg_write  = ctrl_q.reg_write;
    ex_mem_read   = ctrl_q.mem_read;
    ex_mem_write  = ctrl_q.mem_write;
    ex_mem_to_reg = ctrl_q.mem_to_reg;
    ex_dest       = ctrl_q.reg_dst ? rd_q : rt_q;
  end

  // A load in execute whose target feeds the instruction in decode must stall it.
  always_comb begin
    load_use = valid_q && ctrl_q.mem_read && id_valid && (ex_dest != '0) &&
               ((ex_dest == id_rs) || (ex_dest == id_rt));
  end

endmodule
